fp_mul: RTL and testbench

//  Multi-cycle IEEE-754 binary floating-point multiplier, generic in total width and exponent width.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_round_pack.sv | 93 +++++++++
 rtl/fp_mul.sv | 142 ++++++++++++++
 tb/tb_fp_mul.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 multiplier: width derivations, operand classes,
// the multiplier FSM states and the canonical quiet-NaN pattern.
package fp_pkg;

  function automatic int unsigned fp_width(input int unsigned log_bit);
    return 32'd1 << log_bit;
  endfunction

  function automatic int unsigned fp_man_bits(input int unsigned log_bit, input int unsigned exp_bit);
    return fp_width(log_bit) - 32'd1 - exp_bit;
  endfunction

  function automatic int unsigned fp_bias(input int unsigned exp_bit);
    return (32'd1 << (exp_bit - 32'd1)) - 32'd1;
  endfunction

  // {0, all-ones exponent, 1, zeros}, right-aligned; callers truncate to their width
  function automatic logic [127:0] fp_qnan(input int unsigned exp_bit, input int unsigned man_bit);
    logic [127:0] v;
    v = ((128'd1 << (exp_bit + 32'd1)) - 128'd1) << (man_bit - 32'd1);
    return v;
  endfunction

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} fp_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Normalizes the raw significand product (registered on norm_en_i), then applies RNE,
// overflow-to-infinity and packs the result fields combinationally.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned LOG_BIT = 6,
  parameter int unsigned EXP_BIT = 11,
  localparam int unsigned W       = fp_width(LOG_BIT),
  localparam int unsigned MAN_BIT = fp_man_bits(LOG_BIT, EXP_BIT),
  localparam int unsigned BIAS    = fp_bias(EXP_BIT),
  localparam int unsigned PW      = 2 * (MAN_BIT + 1),
  localparam int unsigned EW      = EXP_BIT + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 norm_en_i,
  input  logic                 sign_i,
  input  logic signed [EW-1:0] exp_i,
  input  logic [PW-1:0]        sig_i,
  input  logic                 sticky_i,
  output logic [W-1:0]         res_o
);
  localparam int unsigned LZW = $clog2(PW + 1);
  localparam int unsigned MAXE = (1 << EXP_BIT) - 1;
  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'(MAXE);
  localparam logic signed [EW-1:0] E_PW  = EW'(PW);

  logic [LZW-1:0]        lz, sh;
  logic signed [EW-1:0]  be, shn;
  logic [PW-1:0]         pn;
  logic [PW-2:0]         src;
  logic [EXP_BIT-1:0]    expf;
  logic                  sub, lost, ovf_d, g_d, st_d;
  logic [W-2:0]          field_d;

  logic                  sign_q, ovf_q, g_q, st_q;
  logic [W-2:0]          field_q;

  always_comb begin
    lz = LZW'(PW);
    for (int unsigned i = 0; i < PW; i++) begin
      if (sig_i[i]) lz = LZW'(PW - 1 - i);
    end
    // sig_i is scaled so that a leading one at bit PW-2 means exponent exp_i
    be   = exp_i + EW'(BIAS + 1) - EW'(lz);
    pn   = sig_i << lz;
    sub  = (be < E_ONE);
    shn  = E_ONE - be;
    sh   = (shn > E_PW) ? LZW'(PW) : LZW'(shn);
    src  = pn[PW-2:0];
    lost = 1'b0;
    expf = be[EXP_BIT-1:0];
    if (sub) begin
      src  = (PW-1)'(pn >> sh);
      lost = |(pn & ~({PW{1'b1}} << sh));
      expf = '0;
    end
    ovf_d   = !sub && (be >= E_MAX);
    field_d = {expf, src[PW-2 -: MAN_BIT]};
    g_d     = src[PW-2-MAN_BIT];
    st_d    = (|src[PW-3-MAN_BIT:0]) | lost | sticky_i;
    if (!pn[PW-1]) begin
      ovf_d   = 1'b0;
      field_d = '0;
      g_d     = 1'b0;
      st_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      g_q     <= 1'b0;
      st_q    <= 1'b0;
      field_q <= '0;
    end else if (norm_en_i) begin
      sign_q  <= sign_i;
      ovf_q   <= ovf_d;
      g_q     <= g_d;
      st_q    <= st_d;
      field_q <= field_d;
    end
  end

  // Rounding increments the packed {exp, man} word so mantissa carry bumps the exponent
  always_comb begin
    if (ovf_q) res_o = {sign_q, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    else       res_o = {sign_q, field_q + (W-1)'(g_q & (st_q | field_q[0]))};
  end

endmodule

// File: rtl/fp_mul.sv
// Multi-cycle IEEE-754 multiplier: operand classification, shift-add significand product,
// then normalize/round through fp_round_pack. Start/ready handshake.
module fp_mul
  import fp_pkg::*;
#(
  parameter int unsigned LOG_BIT = 6,
  parameter int unsigned EXP_BIT = 11,
  localparam int unsigned W       = fp_width(LOG_BIT),
  localparam int unsigned MAN_BIT = fp_man_bits(LOG_BIT, EXP_BIT),
  localparam int unsigned BIAS    = fp_bias(EXP_BIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         ready
);
  localparam int unsigned SIG = MAN_BIT + 1;
  localparam int unsigned PW  = 2 * SIG;
  localparam int unsigned EW  = EXP_BIT + 3;
  localparam int unsigned CW  = $clog2(SIG + 1);
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_BIT, MAN_BIT));

  fp_state_t             state_q, state_d;
  logic [W-1:0]          a_q, b_q, spec_val_q, out_q, rp_res, sp_val;
  logic                  sign_q, spec_q, ready_q, accept, sp_hit, sp_sign;
  logic signed [EW-1:0]  exp_q;
  logic [PW-1:0]         mcand_q, acc_q;
  logic [SIG-1:0]        mplier_q;
  logic [CW-1:0]         cnt_q;
  fp_class_t             ca, cb;

  function automatic fp_class_t classify(input logic [W-1:0] x);
    if (x[W-2 -: EXP_BIT] == '0) return (x[MAN_BIT-1:0] == '0) ? ZERO : SUB;
    if (x[W-2 -: EXP_BIT] == '1) return (x[MAN_BIT-1:0] == '0) ? INF : NAN;
    return NORM;
  endfunction

  function automatic logic signed [EW-1:0] unb_exp(input logic [W-1:0] x);
    if (x[W-2 -: EXP_BIT] == '0) return EW'(1) - EW'(BIAS);
    return EW'(x[W-2 -: EXP_BIT]) - EW'(BIAS);
  endfunction

  function automatic logic [SIG-1:0] sig_of(input logic [W-1:0] x);
    return {|x[W-2 -: EXP_BIT], x[MAN_BIT-1:0]};
  endfunction

  always_comb begin
    ca      = classify(a_q);
    cb      = classify(b_q);
    sp_sign = a_q[W-1] ^ b_q[W-1];
    sp_hit  = 1'b1;
    sp_val  = QNAN;
    if (ca == NAN || cb == NAN)                                 sp_val = QNAN;
    else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) sp_val = QNAN;
    else if (ca == INF || cb == INF)   sp_val = {sp_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
    else if (ca == ZERO || cb == ZERO) sp_val = {sp_sign, {(W-1){1'b0}}};
    else                               sp_hit = 1'b0;
  end

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_UNPACK;
      S_UNPACK:       state_d = S_MUL;
      S_MUL:          if (cnt_q == CW'(SIG - 1)) state_d = S_NORM;
      S_NORM:         state_d = S_ROUND;
      S_ROUND:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      out_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // ready is registered from DONE, one edge after the result lands in out_q
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        ready_q <= 1'b0;
      end else if (state_q == S_DONE) begin
        ready_q <= 1'b1;
      end
      case (state_q)
        S_UNPACK: begin
          sign_q     <= sp_sign;
          exp_q      <= unb_exp(a_q) + unb_exp(b_q);
          mcand_q    <= PW'(sig_of(a_q));
          mplier_q   <= sig_of(b_q);
          acc_q      <= '0;
          cnt_q      <= '0;
          spec_q     <= sp_hit;
          spec_val_q <= sp_val;
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_ROUND: out_q <= spec_q ? spec_val_q : rp_res;
        default: ;
      endcase
    end
  end

  fp_round_pack #(
    .LOG_BIT(LOG_BIT),
    .EXP_BIT(EXP_BIT)
  ) u_round_pack (
    .clk      (clk),
    .rst      (rst),
    .norm_en_i(state_q == S_NORM),
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .sig_i    (acc_q),
    .sticky_i (1'b0),
    .res_o    (rp_res)
  );

  assign out   = out_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_fp_mul.sv
// Bench for fp_mul (binary64): directed IEEE cases plus a randomized sweep checked
// against the host double-precision multiply.
module tb_fp_mul;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] dout;
  logic        ready;
  int          total = 0;
  int          bad = 0;

  localparam int LAT = 57;

  always #5 clk = ~clk;

  fp_mul #(.LOG_BIT(6), .EXP_BIT(11)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .out(dout), .ready(ready)
  );

  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    real r;
    logic [63:0] rb;
    r  = $bitstoreal(x) * $bitstoreal(y);
    rb = $realtobits(r);
    if (rb[62:52] == 11'h7FF && rb[51:0] != 52'd0) rb = 64'h7FF8_0000_0000_0000;
    return rb;
  endfunction

  function automatic logic [63:0] gen_op(input int unsigned cat);
    logic [51:0] m;
    logic [10:0] e;
    logic        s;
    m = {20'($urandom()), 32'($urandom())};
    s = 1'($urandom());
    case (cat)
      0: begin e = 11'd0; if (m == 52'd0) m = 52'd1; end
      1: e = 11'($urandom_range(1, 60));
      2: e = 11'($urandom_range(923, 1123));
      default: e = 11'($urandom_range(1990, 2046));
    endcase
    return {s, e, m};
  endfunction

  // Issues one operation; lat is edges from the accept edge to ready=1, or -1 on timeout
  task automatic do_op(input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] res, output int lat);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) lat = -1;
    res = dout;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++;
    if (dout !== 64'd0) begin bad++; $display("FAIL reset_out: got %h want 0", dout); end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int first_hi;
    @(posedge clk); #1;
    a = 64'h3FF0_0000_0000_0000; b = 64'h4000_0000_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_hi = -1;
    for (int e = 1; e <= 62; e++) begin
      @(posedge clk); #1;
      if (ready === 1'b1 && first_hi < 0) first_hi = e;
    end
    total++;
    if (first_hi != LAT) begin bad++; $display("FAIL latency_edge: got %0d want %0d", first_hi, LAT); end
    total++;
    if (dout !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL latency_result: got %h want 4000000000000000", dout);
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_held: got %b want 1", ready); end
  endtask

  task automatic test_specials;
    logic [63:0] va [0:6] = '{64'h7FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h0000_0000_0000_0000,
                              64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'h4000_0000_0000_0000};
    logic [63:0] vb [0:6] = '{64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000,
                              64'h0000_0000_0000_0000, 64'hFFF4_0000_0000_0001, 64'h4000_0000_0000_0000,
                              64'hFFF0_0000_0000_0000};
    logic [63:0] ex [0:6] = '{64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000,
                              64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'hFFF0_0000_0000_0000};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], res, lat);
      total++;
      if (res !== ex[i]) begin bad++; $display("FAIL special[%0d]: got %h want %h", i, res, ex[i]); end
      total++;
      if (lat != LAT) begin bad++; $display("FAIL special_lat[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_subnormal;
    logic [63:0] va [0:2] = '{64'h0000_0000_0000_0001, 64'h000F_FFFF_FFFF_FFFF, 64'h8008_0000_0000_0000};
    logic [63:0] vb [0:2] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000};
    logic [63:0] ex [0:2] = '{64'h0000_0000_0000_0002, 64'h001F_FFFF_FFFF_FFFE, 64'h8004_0000_0000_0000};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], res, lat);
      total++;
      if (res !== ex[i]) begin bad++; $display("FAIL subnormal[%0d]: got %h want %h", i, res, ex[i]); end
    end
  endtask

  task automatic test_range;
    logic [63:0] va [0:3] = '{64'h0000_0000_0000_0001, 64'h7FEF_FFFF_FFFF_FFFF,
                              64'h0000_0000_0000_0001, 64'h0000_0000_0000_0003};
    logic [63:0] vb [0:3] = '{64'h000F_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
                              64'hBFE0_0000_0000_0000, 64'h3FE0_0000_0000_0000};
    logic [63:0] ex [0:3] = '{64'h0000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                              64'h8000_0000_0000_0000, 64'h0000_0000_0000_0002};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], res, lat);
      total++;
      if (res !== ex[i]) begin bad++; $display("FAIL range[%0d]: got %h want %h", i, res, ex[i]); end
    end
  endtask

  task automatic test_rne;
    logic [63:0] res;
    int lat;
    do_op(64'h3FF0_0000_0000_0001, 64'h3FF8_0000_0000_0000, res, lat);
    total++;
    if (res !== 64'h3FF8_0000_0000_0002) begin
      bad++; $display("FAIL rne_tie: got %h want 3ff8000000000002", res);
    end
    do_op(64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, res, lat);
    total++;
    if (res !== 64'h3FF0_0000_0000_0002) begin
      bad++; $display("FAIL rne_below_half: got %h want 3ff0000000000002", res);
    end
  endtask

  task automatic test_sweep;
    logic [63:0] ops_a [20];
    logic [63:0] ops_b [20];
    logic [63:0] res, exp_v;
    int lat;
    for (int i = 0; i < 20; i++) begin
      ops_a[i] = gen_op(i % 4);
      ops_b[i] = gen_op((i / 5) % 4);
    end
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 20; j++) begin
        do_op(ops_a[i], ops_b[j], res, lat);
        exp_v = ref_mul(ops_a[i], ops_b[j]);
        total++;
        if (res !== exp_v || lat != LAT) begin
          bad++;
          $display("FAIL sweep %h*%h: got %h lat %0d want %h lat %0d", ops_a[i], ops_b[j], res, lat, exp_v, LAT);
        end
      end
    end
  endtask

  task automatic test_back_to_back_start_ignored;
    int lat;
    logic [63:0] exp_v;
    exp_v = ref_mul(64'h3FF8_0000_0000_0000, 64'h4008_0000_0000_0000);
    @(posedge clk); #1;
    a = 64'h3FF8_0000_0000_0000; b = 64'h4008_0000_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (ready !== 1'b1 && lat < 200) begin
      if (lat == 10) begin a = 64'h4010_0000_0000_0000; b = 64'h4010_0000_0000_0000; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (lat != LAT) begin bad++; $display("FAIL busy_start_lat: got %0d want %0d", lat, LAT); end
    total++;
    if (dout !== exp_v) begin bad++; $display("FAIL busy_start_result: got %h want %h", dout, exp_v); end
  endtask

  task automatic test_reset_midop;
    logic [63:0] res;
    int lat;
    @(posedge clk); #1;
    a = 64'h4000_0000_0000_0000; b = 64'h4000_0000_0000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midop_rst_ready: got %b want 0", ready); end
    total++;
    if (dout !== 64'd0) begin bad++; $display("FAIL midop_rst_out: got %h want 0", dout); end
    repeat (70) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midop_rst_idle: got %b want 0", ready); end
    do_op(64'hC000_0000_0000_0000, 64'h4010_0000_0000_0000, res, lat);
    total++;
    if (res !== 64'hC020_0000_0000_0000 || lat != LAT) begin
      bad++; $display("FAIL post_reset_op: got %h lat %0d want c020000000000000 lat %0d", res, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_specials();
    test_subnormal();
    test_range();
    test_rne();
    test_back_to_back_start_ignored();
    test_sweep();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
